// File: rtl/fir_xifu_pkg.sv
// Shared XIFU types and defaults: instruction opcodes and datapath/scoreboard sizing.
package fir_xifu_pkg;

  localparam int unsigned XIFU_XLEN   = 32;
  localparam int unsigned XIFU_NUM_ID = 4;

  typedef enum logic [1:0] {
    INVALID  = 2'd0,
    XFIRLW   = 2'd1,
    XFIRSW   = 2'd2,
    XFIRDOTP = 2'd3
  } instr_t;

  // Loads and stores both wait on a memory response before they can retire.
  function automatic logic is_mem_op(input instr_t instr);
    return (instr == XFIRLW) || (instr == XFIRSW);
  endfunction

endpackage

// File: rtl/fir_xifu_wb_fifo.sv
// Memory-result FIFO, DEPTH entries, one-cycle write-to-read; full push with pop is accepted.
// Full push without pop drops data and raises a sticky overflow flag; flush empties but keeps the flag.
module fir_xifu_wb_fifo #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] head_o,
  output logic            empty_o,
  output logic            full_o,
  output logic            ovf_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             do_push, do_pop, overflow;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign empty_o  = (cnt_q == '0);
  assign full_o   = (cnt_q == CNT_W'(DEPTH));
  assign do_pop   = pop_i & ~empty_o;
  assign do_push  = push_i & (~full_o | do_pop);
  assign overflow = push_i & full_o & ~do_pop & ~flush_i;
  assign head_o   = mem_q[rd_ptr_q];
  assign ovf_o    = ovf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= ovf_q | overflow;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
        if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
        if (do_push && !do_pop)      cnt_q <= cnt_q + CNT_W'(1);
        else if (do_pop && !do_push) cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fir_xifu_wb_buf.sv
// XIFU writeback buffer: one held instruction retires >=1 cycle after EX accept once committed (and memory data present).
// ready_o drops while an unretired instruction is held; forwarding outputs exist only with FIR_XIFU_WB_FWD_EN.
module fir_xifu_wb_buf
  import fir_xifu_pkg::*;
#(
  parameter int unsigned XLEN   = XIFU_XLEN,
  parameter int unsigned NUM_ID = XIFU_NUM_ID,
  parameter int unsigned DEPTH  = 2,
  localparam int unsigned ID_W  = (NUM_ID > 1) ? $clog2(NUM_ID) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ex_valid_i,
  input  instr_t            ex_instr_i,
  input  logic [ID_W-1:0]   ex_id_i,
  input  logic [4:0]        ex_rd_i,
  input  logic [4:0]        ex_rs1_i,
  input  logic [XLEN-1:0]   ex_result_i,
  output logic              ready_o,
  input  logic              mem_valid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  input  logic [NUM_ID-1:0] issue_i,
  input  logic [NUM_ID-1:0] commit_i,
  input  logic [NUM_ID-1:0] kill_i,
  output logic [NUM_ID-1:0] clear_o,
  output logic              result_valid_o,
  input  logic              result_ready_i,
  output logic [ID_W-1:0]   result_id_o,
  output logic [XLEN-1:0]   result_data_o,
  output logic [4:0]        result_rd_o,
  output logic              result_we_o,
  output logic              rf_write_o,
  output logic [4:0]        rf_rd_o,
  output logic [XLEN-1:0]   rf_result_o,
  output logic              fwd_we_o,
  output logic [4:0]        fwd_rd_o,
  output logic [XLEN-1:0]   fwd_result_o,
  output logic              kill_o,
  output logic              ovf_o
);

  logic            valid_q;
  instr_t          instr_q;
  logic [ID_W-1:0] id_q;
  logic [4:0]      rd_q, rs1_q;
  logic [XLEN-1:0] result_q;

  logic            mem_op, dotp, retire, load, bypass;
  logic            fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [XLEN-1:0] fifo_head, mem_data;
  logic            unused_issue;

  // Retirement does not depend on issue state.
  assign unused_issue = ^issue_i;

  assign mem_op = is_mem_op(instr_q);
  assign dotp   = (instr_q == XFIRDOTP);
  assign kill_o = valid_q & kill_i[id_q];

  assign result_valid_o = valid_q & commit_i[id_q] & ~kill_i[id_q] &
                          (dotp | (mem_op & (~fifo_empty | mem_valid_i)));
  assign retire  = result_valid_o & result_ready_i;
  assign ready_o = ~valid_q | retire;
  assign load    = ex_valid_i & ready_o & (ex_instr_i != INVALID);

  // An empty FIFO means the retiring memory op takes this cycle's response directly.
  assign mem_data  = fifo_empty ? mem_rdata_i : fifo_head;
  assign bypass    = retire & mem_op & fifo_empty;
  assign fifo_push = mem_valid_i & ~bypass;
  assign fifo_pop  = retire & mem_op & ~fifo_empty;

  assign clear_o       = retire ? (NUM_ID'(1) << id_q) : '0;
  assign result_id_o   = id_q;
  assign result_data_o = result_q;
  assign result_rd_o   = rs1_q;
  assign result_we_o   = mem_op;

  assign rf_write_o = retire & ((instr_q == XFIRLW) | dotp);
  assign rf_rd_o    = rd_q;

  always_comb begin
    rf_result_o = '0;
    case (instr_q)
      XFIRDOTP: rf_result_o = result_q;
      XFIRLW:   rf_result_o = mem_data;
      default:  rf_result_o = '0;
    endcase
  end

`ifdef FIR_XIFU_WB_FWD_EN
  assign fwd_we_o     = result_valid_o & result_we_o;
  assign fwd_rd_o     = result_rd_o;
  assign fwd_result_o = result_data_o;
`else
  assign fwd_we_o     = 1'b0;
  assign fwd_rd_o     = '0;
  assign fwd_result_o = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= 1'b0;
      instr_q  <= INVALID;
      id_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      result_q <= '0;
    end else begin
      if (kill_o) begin
        valid_q <= 1'b0;
      end else if (load) begin
        valid_q  <= 1'b1;
        instr_q  <= ex_instr_i;
        id_q     <= ex_id_i;
        rd_q     <= ex_rd_i;
        rs1_q    <= ex_rs1_i;
        result_q <= ex_result_i;
      end else if (retire) begin
        valid_q <= 1'b0;
      end
    end
  end

  fir_xifu_wb_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (kill_o),
    .data_i  (mem_rdata_i),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .ovf_o   (ovf_o)
  );

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: doc/fir_xifu_wb_buf.md
FIR_XIFU_WB_BUF -- requirements
Module: fir_xifu_wb_buf

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter NUM_ID, default 4, scoreboard entries; ID_W = $clog2(NUM_ID).
REQ-003 SHALL have parameter DEPTH, default 2, memory-result FIFO depth (>=1).
REQ-004 SHALL have ports, clock and reset first: one clock; reset is asynchronous and active-low.
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- ex_valid_i  in  1  EX offers instruction
- ex_instr_i  in  instr_t  opcode (INVALID/XFIRLW/XFIRSW/XFIRDOTP)
- ex_id_i  in  ID_W  instruction id
- ex_rd_i  in  5  XIFU destination register
- ex_rs1_i  in  5  core base-address register
- ex_result_i  in  XLEN  dotp result / incremented address
- ready_o  out  1  WB accepts from EX
- mem_valid_i  in  1  memory result strobe
- mem_rdata_i  in  XLEN  memory read data
- issue_i, commit_i, kill_i  in  NUM_ID each  scoreboard state per id
- clear_o  out  NUM_ID  one-hot scoreboard clear
- result_valid_o  out  1 / result_ready_i  in  1  core result handshake
- result_id_o  out  ID_W; result_data_o  out  XLEN; result_rd_o  out  5; result_we_o  out  1
- rf_write_o  out  1; rf_rd_o  out  5; rf_result_o  out  XLEN  XIFU regfile write
- fwd_we_o  out  1; fwd_rd_o  out  5; fwd_result_o  out  XLEN  forwarding to EX
- kill_o  out  1  pipeline flush request
- ovf_o  out  1  sticky FIFO overflow error

Function
REQ-005 SHALL hold one instruction in register (valid_q, fields); load on ex_valid_i & ready_o & instr!=INVALID.
REQ-006 SHALL drive ready_o = ~valid_q | retire, retire = result_valid_o & result_ready_i.
REQ-007 SHALL push mem_rdata_i into DEPTH-entry FIFO on every mem_valid_i, independent of valid_q.
REQ-008 SHALL assert result_valid_o: DOTP when valid_q & commit_i[id]; LW/SW when valid_q & commit_i[id] & (FIFO non-empty | mem_valid_i bypass).
REQ-009 SHALL, combinationally same cycle as retire: clear_o[id]=1; pop FIFO (LW/SW, or consume bypass without push).
REQ-010 SHALL drive rf_write_o = retire & instr in {LW, DOTP}; rf_rd_o = held rd; rf_result_o = FIFO head/bypass (LW) or held result (DOTP).
REQ-011 SHALL drive result_id_o = id, result_data_o = held result, result_rd_o = held rs1, result_we_o = instr in {LW, SW}.
REQ-012 SHALL hold all result_* stable while result_valid_o & ~result_ready_i.
REQ-013 SHALL drive kill_o = valid_q & kill_i[id]; same cycle: no retire; next edge valid_q=0, FIFO flushed.
REQ-014 SHALL accept simultaneous push and pop when FIFO full (occupancy unchanged).
REQ-015 SHALL, on push when full without pop, drop data and set ovf_o until reset.
REQ-016 SHALL wrap FIFO pointers modulo DEPTH; count width $clog2(DEPTH+1).
REQ-017 SHALL ignore issue_i except ready_o requires no other dependency; latency EX accept to earliest retire: 1 cycle.

Reset
REQ-018 SHALL on rst_ni low: valid_q=0, FIFO empty, ovf_o=0; all outputs 0 except ready_o=1.
REQ-019 SHALL discard held instruction and FIFO contents when reset asserts mid-operation.

Configuration
REQ-020 SHALL, with FIR_XIFU_WB_FWD_EN defined, drive fwd_we_o=result_valid_o & result_we_o, fwd_rd_o=result_rd_o, fwd_result_o=result_data_o.
REQ-021 SHALL, without FIR_XIFU_WB_FWD_EN, tie fwd_we_o, fwd_rd_o, fwd_result_o to 0.

Structure
REQ-022 SHALL take instr_t enum and default constants (XIFU_XLEN, XIFU_NUM_ID) from fir_xifu_pkg.
REQ-023 SHALL instantiate sub-module fir_xifu_wb_fifo (parametrised XLEN, DEPTH; push, pop, flush, head, empty, full).

Verification
REQ-024 DOTP id=1 result=0x12345678, commit_i[1]=1, result_ready_i=1 -> same cycle rf_write_o=1, rf_result_o=0x12345678, clear_o=4'b0010, result_we_o=0.
REQ-025 LW id=0 committed, mem_valid_i 3 cycles later rdata=0xCAFEF00D -> retire that cycle via bypass, rf_result_o=0xCAFEF00D, result_rd_o=rs1, FIFO stays empty.
REQ-026 Two mem results (0xA, 0xB) before two LW enter WB, DEPTH=2 -> LWs retire in order with 0xA then 0xB, ovf_o=0.
REQ-027 DEPTH=2 FIFO full, third mem_valid_i without pop -> ovf_o=1 sticky; with simultaneous pop -> ovf_o=0.
REQ-028 result_ready_i=0 for 4 cycles with valid result -> outputs stable, ready_o=0, clear_o=0 until handshake.
REQ-029 kill_i[2] while id=2 SW held -> kill_o=1 one cycle, no clear_o, next cycle ready_o=1, FIFO empty.
